// File: rtl/multicycle_hart_if.sv
// Shared word-wide memory port of the multi-cycle hart: one request at a time,
// completed by a single-cycle ready from the memory side.
interface multicycle_hart_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/multicycle_hart.sv
// Multi-cycle RV32I-subset hart (OP-IMM, LOAD, STORE) on one shared memory port.
// Any fault parks the hart in HALT until reset.
module multicycle_hart #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_hart_if.master   mem,
  output logic                retire,
  output logic                halted,
  output logic [1:0]          trap_cause,
  output logic [31:0]         pc_out,
  input  logic [4:0]          dbg_raddr,
  output logic [31:0]         dbg_rdata
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc, ir;
  logic [1:0]  ea_lo;
  logic [31:0] xregs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, rs1_v, rs2_v, ea, pc_next;
  logic        is_opimm, is_load, is_store, ldst_ok, misal;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign shamt  = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : xregs[rs1];
  assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : xregs[rs2];
  assign pc_next = pc + 32'd4;

  assign is_opimm = (opcode == 7'b0010011);
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign ea       = rs1_v + (is_store ? imm_s : imm_i);
  assign ldst_ok  = (is_load  && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) ||
                    (is_store && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2));
  // f3[1:0] encodes access size for both loads and stores (LBU/LHU share it)
  assign misal    = (f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);

  logic [31:0] alu_res;
  logic        alu_ok;
  always_comb begin
    alu_res = 32'd0;
    alu_ok  = 1'b1;
    case (f3)
      3'd0: alu_res = rs1_v + imm_i;
      3'd2: alu_res = {31'd0, $signed(rs1_v) < $signed(imm_i)};
      3'd3: alu_res = {31'd0, rs1_v < imm_i};
      3'd4: alu_res = rs1_v ^ imm_i;
      3'd6: alu_res = rs1_v | imm_i;
      3'd7: alu_res = rs1_v & imm_i;
      3'd1: begin
        alu_res = rs1_v << shamt;
        alu_ok  = (ir[31:25] == 7'b0000000);
      end
      default: begin
        if (ir[31:25] == 7'b0100000) alu_res = $unsigned($signed(rs1_v) >>> shamt);
        else                         alu_res = rs1_v >> shamt;
        alu_ok = (ir[31:25] == 7'b0000000) || (ir[31:25] == 7'b0100000);
      end
    endcase
  end

  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_lane, ld_val;
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2_v;
    case (f3[1:0])
      2'b00:   begin st_be = 4'b0001 << ea[1:0]; st_wdata = {4{rs2_v[7:0]}};  end
      2'b01:   begin st_be = 4'b0011 << ea[1:0]; st_wdata = {2{rs2_v[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    ld_lane = mem.mem_rdata >> {ea_lo, 3'b000};
    case (f3)
      3'd0:    ld_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'd1:    ld_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'd4:    ld_val = {24'd0, ld_lane[7:0]};
      3'd5:    ld_val = {16'd0, ld_lane[15:0]};
      default: ld_val = ld_lane;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wdata;
  assign rf_we    = !reset && rd != 5'd0 &&
                    ((state == S_EXEC && is_opimm && alu_ok) ||
                     (state == S_MEM && mem.mem_ready && !mem.mem_we));
  assign rf_wdata = (state == S_MEM) ? ld_val : alu_res;

  always_ff @(posedge clock) begin
    if (rf_we) xregs[rd] <= rf_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      ir            <= 32'd0;
      ea_lo         <= 2'd0;
      retire        <= 1'b0;
      halted        <= 1'b0;
      trap_cause    <= 2'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b1111;
      mem.mem_wdata <= 32'd0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          // first fetch after reset needs one cycle to raise the registered request
          if (!mem.mem_req) begin
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'b1111;
            mem.mem_addr <= {pc[ADDR_W-1:2], 2'b00};
          end else if (mem.mem_ready) begin
            ir          <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_opimm && alu_ok) begin
            pc           <= pc_next;
            retire       <= 1'b1;
            state        <= S_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'b1111;
            mem.mem_addr <= {pc_next[ADDR_W-1:2], 2'b00};
          end else if (ldst_ok && misal) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            trap_cause <= is_load ? 2'd2 : 2'd3;
          end else if (ldst_ok) begin
            state         <= S_MEM;
            ea_lo         <= ea[1:0];
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_be    <= is_store ? st_be : 4'b1111;
            mem.mem_wdata <= st_wdata;
            mem.mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
          end else begin
            state      <= S_HALT;
            halted     <= 1'b1;
            trap_cause <= 2'd1;
          end
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            pc           <= pc_next;
            retire       <= 1'b1;
            state        <= S_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'b1111;
            mem.mem_addr <= {pc_next[ADDR_W-1:2], 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out    = pc;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : xregs[dbg_raddr];
endmodule
